// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial operand link: FSM encoding,
// UART frame geometry and an index-width helper.
package serial_link_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    READY   = 2'd1,
    SEND    = 2'd2
  } link_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Width of a counter/index that must hold values 0..n-1 (never below 1).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 receiver: 2-flop synchroniser, start-bit re-check at
// half a bit, mid-bit data/stop sampling, byte strobe or framing-error strobe.
module uart_rx_core
  import serial_link_pkg::*;
#(
  parameter int SAMPLE_DIV   = 651,
  parameter int SAMPLE_RATIO = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 din,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int DIV_W = idx_w(SAMPLE_DIV);
  localparam int SMP_W = idx_w(SAMPLE_RATIO);
  localparam int BIT_W = idx_w(DATA_BITS);

  logic [1:0]           sync;
  logic                 rx_prev;
  rx_state_t            state;
  logic [DIV_W-1:0]     div_cnt;
  logic [SMP_W-1:0]     smp_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_in, tick, half_smp, full_smp;

  assign rx_in    = sync[1];
  assign tick     = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign half_smp = tick && (smp_cnt == SMP_W'(SAMPLE_RATIO / 2 - 1));
  assign full_smp = tick && (smp_cnt == SMP_W'(SAMPLE_RATIO - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync         <= 2'b11;
      rx_prev      <= 1'b1;
      state        <= RX_IDLE;
      div_cnt      <= '0;
      smp_cnt      <= '0;
      bit_cnt      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[0], din};
      rx_prev      <= rx_in;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (state != RX_IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) smp_cnt <= (smp_cnt == SMP_W'(SAMPLE_RATIO - 1)) ? '0 : smp_cnt + 1'b1;
      end
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_in) begin
            state   <= RX_START;
            div_cnt <= '0;
            smp_cnt <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again by mid-bit was a glitch.
          if (half_smp) begin
            smp_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_in ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (full_smp) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (full_smp) begin
            state <= RX_IDLE;
            if (rx_in) rx_valid     <= 1'b1;
            else       rx_frame_err <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RX_DATA && full_smp) shift <= {rx_in, shift[DATA_BITS-1:1]};
  end

  assign rx_byte = shift;

endmodule

// File: rtl/serial_operand_link.sv
// UART operand collector / result transmitter for the calculator ALU.
// Optional inter-byte timeout built when SERIAL_LINK_TIMEOUT_EN is defined.
module serial_operand_link
  import serial_link_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int SAMPLE_RATIO  = 16,
  parameter int OPERAND_COUNT = 2,
  parameter int OPERAND_BYTES = 1,
  parameter int RESULT_BYTES  = 1,
  parameter int TIMEOUT_BAUDS = 20
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   din,
  output logic                                   dout,
  output logic [OPERAND_COUNT*OPERAND_BYTES*8-1:0] operands,
  output logic                                   ready,
  input  logic [RESULT_BYTES*8-1:0]              result,
  input  logic                                   tx_en,
  output logic                                   tx_busy,
  output logic                                   frame_error,
  output logic                                   rx_overrun,
  output logic                                   timeout
);

  localparam int SAMPLE_DIV = CLK_FREQUENCY / BAUD_RATE / SAMPLE_RATIO;
  localparam int BIT_PERIOD = SAMPLE_DIV * SAMPLE_RATIO;
  localparam int N          = OPERAND_COUNT * OPERAND_BYTES;
  localparam int RSW        = RESULT_BYTES * DATA_BITS;
  localparam int IDX_W      = idx_w(N);
  localparam int TXI_W      = idx_w(RESULT_BYTES);
  localparam int TMR_W      = idx_w(BIT_PERIOD);
  localparam int FB_W       = idx_w(FRAME_BITS);

  if (OPERAND_COUNT < 1 || OPERAND_BYTES < 1 || RESULT_BYTES < 1 ||
      TIMEOUT_BAUDS < 1 || SAMPLE_DIV < 1 || SAMPLE_RATIO < 2) begin : g_bad_cfg
    $error("serial_operand_link: invalid parameter set");
  end

  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_valid;
  link_state_t          state;
  logic [IDX_W-1:0]     byte_idx;
  logic [TMR_W-1:0]     bit_timer;
  logic [FB_W-1:0]      tx_bit;
  logic [TXI_W-1:0]     tx_idx;
  logic [RSW-1:0]       tx_shift;
  logic                 accept, bit_end, frame_end, next_byte, store, to_fire;

  uart_rx_core #(
    .SAMPLE_DIV  (SAMPLE_DIV),
    .SAMPLE_RATIO(SAMPLE_RATIO)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(frame_error)
  );

  assign accept    = (state == READY) && tx_en;
  assign bit_end   = (bit_timer == TMR_W'(BIT_PERIOD - 1));
  assign frame_end = (state == SEND) && bit_end && (tx_bit == FB_W'(FRAME_BITS - 1));
  assign next_byte = frame_end && (tx_idx != TXI_W'(RESULT_BYTES - 1));
  assign store     = rx_valid && (state == COLLECT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= COLLECT;
      byte_idx   <= '0;
      ready      <= 1'b0;
      tx_busy    <= 1'b0;
      dout       <= 1'b1;
      bit_timer  <= '0;
      tx_bit     <= '0;
      tx_idx     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_valid && (state != COLLECT);
      case (state)
        COLLECT: begin
          if (rx_valid) begin
            if (byte_idx == IDX_W'(N - 1)) begin
              byte_idx <= '0;
              state    <= READY;
              ready    <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (to_fire) begin
            byte_idx <= '0;
          end
        end
        READY: begin
          if (tx_en) begin
            state     <= SEND;
            ready     <= 1'b0;
            tx_busy   <= 1'b1;
            tx_idx    <= '0;
            tx_bit    <= '0;
            bit_timer <= '0;
            dout      <= 1'b0;
          end
        end
        SEND: begin
          if (bit_end) begin
            bit_timer <= '0;
            if (tx_bit == FB_W'(FRAME_BITS - 1)) begin
              if (tx_idx == TXI_W'(RESULT_BYTES - 1)) begin
                state   <= COLLECT;
                tx_busy <= 1'b0;
                dout    <= 1'b1;
              end else begin
                // Next frame's start bit follows the stop bit with no gap.
                tx_idx <= tx_idx + 1'b1;
                tx_bit <= '0;
                dout   <= 1'b0;
              end
            end else begin
              tx_bit <= tx_bit + 1'b1;
              dout   <= (tx_bit == FB_W'(DATA_BITS)) ? 1'b1 : tx_shift[tx_bit[2:0]];
            end
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)         tx_shift <= result;
    else if (next_byte) tx_shift <= tx_shift >> DATA_BITS;
  end

  // Byte i of the transaction lands at bits [8i +: 8]; untouched slots keep old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operands <= '0;
    end else if (store) begin
      for (int i = 0; i < N; i++) begin
        if (byte_idx == IDX_W'(i)) operands[i*DATA_BITS +: DATA_BITS] <= rx_byte;
      end
    end
  end

`ifdef SERIAL_LINK_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BAUDS * BIT_PERIOD;
  localparam int TO_W      = idx_w(TO_CYCLES);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  assign to_fire = (state == COLLECT) && (byte_idx != '0) && !rx_valid &&
                   (to_cnt == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (rx_valid || state != COLLECT || byte_idx == '0 || to_fire) to_cnt <= '0;
      else                                                          to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serial_operand_link.sv
// Directed bench: default-config link (a) and 2-byte operand/result link (b)
// driven through their serial lines with hand-computed expectations.
module tb_serial_operand_link;

  localparam int CLK_HZ = 1_536_000;
  localparam int BAUD   = 9600;
  localparam int BIT    = 160;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        din_a, din_b, tx_en_a, tx_en_b;
  logic        dout_a, dout_b, ready_a, ready_b, tx_busy_a, tx_busy_b;
  logic        fe_sig_a, fe_sig_b, ovr_sig_a, ovr_sig_b, to_sig_a, to_sig_b;
  logic [15:0] operands_a;
  logic [31:0] operands_b;
  logic [7:0]  result_a;
  logic [15:0] result_b;

  int tests = 0, failed = 0;
  int cyc = 0, ovr_a = 0, fe_a = 0, to_a = 0, ovr_b = 0, fe_b = 0, to_b = 0;
  int busy_b_cnt = 0, last_valid_a = 0, ready_rise_a = 0;
  logic ready_a_d = 1'b0;

  always #5 clk = ~clk;

  serial_operand_link #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .din(din_a), .dout(dout_a), .operands(operands_a),
    .ready(ready_a), .result(result_a), .tx_en(tx_en_a), .tx_busy(tx_busy_a),
    .frame_error(fe_sig_a), .rx_overrun(ovr_sig_a), .timeout(to_sig_a));

  serial_operand_link #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD),
                        .OPERAND_BYTES(2), .RESULT_BYTES(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .din(din_b), .dout(dout_b), .operands(operands_b),
    .ready(ready_b), .result(result_b), .tx_en(tx_en_b), .tx_busy(tx_busy_b),
    .frame_error(fe_sig_b), .rx_overrun(ovr_sig_b), .timeout(to_sig_b));

  always @(negedge clk) begin
    cyc++;
    if (ovr_sig_a) ovr_a++;
    if (fe_sig_a)  fe_a++;
    if (to_sig_a)  to_a++;
    if (ovr_sig_b) ovr_b++;
    if (fe_sig_b)  fe_b++;
    if (to_sig_b)  to_b++;
    if (tx_busy_b) busy_b_cnt++;
    if (u_dut_a.rx_valid) last_valid_a = cyc;
    if (ready_a && !ready_a_d) ready_rise_a = cyc;
    ready_a_d = ready_a;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_din(input bit sel, input logic v);
    if (sel) din_b = v;
    else     din_a = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop_bit, input int idle);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_din(sel, fr[i]);
      repeat (BIT) @(posedge clk);
    end
    set_din(sel, 1'b1);
    repeat (idle) @(posedge clk);
  endtask

  task automatic tx_a_and_wait(input logic [7:0] r);
    result_a = r;
    @(negedge clk) tx_en_a = 1'b1;
    @(negedge clk) tx_en_a = 1'b0;
    for (int i = 0; i < 3000 && tx_busy_a; i++) @(negedge clk);
    check("tx_a_done_busy", tx_busy_a, 1'b0);
  endtask

  initial begin
    logic [19:0] exp_frame;
    int busy0;
    din_a = 1'b1; din_b = 1'b1; tx_en_a = 1'b0; tx_en_b = 1'b0;
    result_a = '0; result_b = '0; reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (5*BIT) @(negedge clk);

    check("reset_dout_a", dout_a, 1'b1);
    check("reset_ready_a", ready_a, 1'b0);
    check("reset_operands_a", operands_a, 16'h0);
    check("reset_busy_a", tx_busy_a, 1'b0);
    check("reset_dout_b", dout_b, 1'b1);
    check("reset_operands_b", operands_b, 32'h0);
    check("reset_no_pulses", ovr_a + fe_a + to_a + ovr_b + fe_b + to_b, 0);

    // tx_en while collecting must be ignored
    @(negedge clk) tx_en_a = 1'b1;
    @(negedge clk) tx_en_a = 1'b0;
    check("txen_ignored_busy", tx_busy_a, 1'b0);
    check("txen_ignored_dout", dout_a, 1'b1);

    send_byte(0, 8'h12, 1'b1, 0);
    send_byte(0, 8'h34, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("collect_operands_a", operands_a, 16'h3412);
    check("collect_ready_a", ready_a, 1'b1);
    check("ready_latency", ready_rise_a - last_valid_a, 1);

    send_byte(0, 8'h99, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("overrun_pulses", ovr_a, 1);
    check("overrun_operands", operands_a, 16'h3412);
    check("overrun_ready", ready_a, 1'b1);

    result_a = 8'h3C;
    @(negedge clk) tx_en_a = 1'b1;
    @(negedge clk) tx_en_a = 1'b0;
    check("accept_busy_a", tx_busy_a, 1'b1);
    check("accept_ready_a", ready_a, 1'b0);
    for (int i = 0; i < 2000 && tx_busy_a; i++) @(negedge clk);
    check("tx_a_finished", tx_busy_a, 1'b0);
    check("tx_a_ready_after", ready_a, 1'b0);

    send_byte(0, 8'h55, 1'b0, BIT);
    repeat (5) @(negedge clk);
    check("frame_error_pulses", fe_a, 1);
    check("frame_error_ready", ready_a, 1'b0);
    check("frame_error_discard", operands_a, 16'h3412);
    send_byte(0, 8'h21, 1'b1, 0);
    send_byte(0, 8'h43, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("after_fe_operands", operands_a, 16'h4321);
    check("after_fe_ready", ready_a, 1'b1);

    send_byte(1, 8'hCD, 1'b1, 0);
    send_byte(1, 8'hAB, 1'b1, 0);
    send_byte(1, 8'h01, 1'b1, 0);
    send_byte(1, 8'h00, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("wide_operand0", operands_b[15:0], 16'hABCD);
    check("wide_operand1", operands_b[31:16], 16'h0001);
    check("wide_ready", ready_b, 1'b1);

    result_b  = 16'hBEEF;
    exp_frame = {1'b1, 8'hBE, 1'b0, 1'b1, 8'hEF, 1'b0};
    busy0     = busy_b_cnt;
    @(negedge clk) tx_en_b = 1'b1;
    @(negedge clk) tx_en_b = 1'b0;
    check("tx_b_busy_rise", tx_busy_b, 1'b1);
    check("tx_b_ready_fall", ready_b, 1'b0);
    check("tx_b_start_low", dout_b, 1'b0);
    repeat (80) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("tx_b_bit%0d", k), dout_b, exp_frame[k]);
      if (k < 19) begin
        repeat (BIT) @(posedge clk);
        @(negedge clk);
      end
    end
    repeat (79) @(posedge clk);
    @(negedge clk);
    check("tx_b_busy_last_cycle", tx_busy_b, 1'b1);
    @(negedge clk);
    check("tx_b_busy_fall", tx_busy_b, 1'b0);
    check("tx_b_dout_idle", dout_b, 1'b1);
    check("tx_b_busy_cycles", busy_b_cnt - busy0, 3200);

    send_byte(1, 8'h77, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("b_back_in_collect", operands_b, 32'h0001_AB77);
    check("b_not_ready", ready_b, 1'b0);

    tx_a_and_wait(8'h00);
    send_byte(0, 8'h12, 1'b1, 3300);
    send_byte(0, 8'h56, 1'b1, 0);
    send_byte(0, 8'h78, 1'b1, 0);
    repeat (5) @(negedge clk);
`ifdef SERIAL_LINK_TIMEOUT_EN
    check("timeout_pulses", to_a, 1);
    check("timeout_operands", operands_a, 16'h7856);
`else
    check("timeout_pulses", to_a, 0);
    check("timeout_operands", operands_a, 16'h5612);
`endif
    check("timeout_ready", ready_a, 1'b1);

    // asynchronous reset while a frame is on the line
    result_a = 8'h00;
    @(negedge clk) tx_en_a = 1'b1;
    @(negedge clk) tx_en_a = 1'b0;
    repeat (200) @(negedge clk);
    check("midframe_dout_low", dout_a, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_dout", dout_a, 1'b1);
    check("async_reset_busy", tx_busy_a, 1'b0);
    check("async_reset_operands", operands_a, 16'h0);
    check("async_reset_ready", ready_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_operand_link.md
# serial_operand_link

Parametrised UART front-end for the calculator datapath: collects a configurable number of multi-byte operands from the serial line, presents them to the ALU with a `ready` flag, and returns a multi-byte result on `tx_en`. It replaces the fixed two-byte, one-byte-result transceiver. It adds frame-error detection, overrun reporting and an optional inter-byte timeout. The block sits between the board UART pins and the CPU/ALU operand and result buses.

## Interface
- `CLK_FREQUENCY`, 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, 9600: line rate; format is 8N1, LSB first.
- `SAMPLE_RATIO`, 16: receive oversampling factor.
- `OPERAND_COUNT`, 2: number of operands per transaction (≥1).
- `OPERAND_BYTES`, 1: bytes per operand; operand width is 8*OPERAND_BYTES.
- `RESULT_BYTES`, 1: bytes transmitted per result (≥1).
- `TIMEOUT_BAUDS`, 20: idle bit periods before a partial transaction is abandoned. Only used with the timeout macro.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial receive line; idle high; asynchronous to clk.
- `dout`  out  1  serial transmit line; idle high.
- `operands`  out  OPERAND_COUNT*OPERAND_BYTES*8  flat operand bus; operand k occupies bits [k*W +: W].
- `ready`  out  1  all operands received; high only in state READY.
- `result`  in  RESULT_BYTES*8  value to transmit; sampled when `tx_en` is accepted.
- `tx_en`  in  1  transmit request; honoured only in READY.
- `tx_busy`  out  1  high while in state SEND.
- `frame_error`  out  1  one-cycle pulse when a received byte has a stop bit of 0.
- `rx_overrun`  out  1  one-cycle pulse when a valid byte arrives outside COLLECT.
- `timeout`  out  1  one-cycle pulse when a partial transaction is abandoned.

## Operation
- Clock ratios: SAMPLE_DIV = CLK_FREQUENCY/BAUD_RATE/SAMPLE_RATIO (integer division). Bit period = SAMPLE_DIV*SAMPLE_RATIO clk cycles.
- Receiver: a falling edge of `din` (after a 2-flop synchroniser) arms the receiver. The start bit is re-checked at sample SAMPLE_RATIO/2; if it is high, the receiver returns to idle silently. Data bits and the stop bit are sampled at mid-bit.
- At the stop-bit sample:
  - stop bit = 1: the receiver issues a one-cycle `rx_valid` strobe with the byte.
  - stop bit = 0: `frame_error` pulses, the byte is discarded, and the byte index is unchanged.
- Byte assembly: the N = OPERAND_COUNT*OPERAND_BYTES received bytes fill `operands` from bit 0 upward. Each operand is little-endian, and operand 0 arrives first. Each byte is written into its slot on its strobe. Operand bits not yet rewritten keep their previous values.
- FSM states: COLLECT, READY, SEND. Reset state is COLLECT with byte index 0.
  - COLLECT: each `rx_valid` increments the index. On byte N-1, the index clears and the FSM moves to READY.
  - READY: `tx_en`=1 latches `result` into the shift register, clears the send byte index and moves to SEND.
  - SEND: transmits RESULT_BYTES frames back-to-back, byte 0 (bits [7:0]) first. After the last stop bit completes, the FSM returns to COLLECT.
- `rx_valid` in READY or SEND: the byte is dropped and `rx_overrun` pulses.
- `tx_en` outside READY is ignored.
- `operands` holds stable from READY until the next byte write in COLLECT.
- Asynchronous reset mid-frame: both the receive and transmit engines abort. State returns to COLLECT. `dout`=1 on the next clock-independent evaluation.

## Timing
- Reset values: `dout`=1, `operands`=0, `ready`=0, `tx_busy`=0, `frame_error`=0, `rx_overrun`=0, `timeout`=0.
- `ready` rises on the clk edge that registers the final `rx_valid`. It is therefore visible one cycle after the strobe.
- `ready` falls and `tx_busy` rises on the edge that accepts `tx_en`. The start bit drives `dout` low starting the cycle after acceptance.
- Each frame lasts exactly 10 bit periods. Frames are contiguous with no idle gap between them.
- `tx_busy` falls on the edge ending the last stop bit.

## Configuration
- `SERIAL_LINK_TIMEOUT_EN` defined:
  - In COLLECT with index > 0, a counter measures clk cycles since the last `rx_valid`.
  - When the count reaches TIMEOUT_BAUDS bit periods, the index clears, `timeout` pulses, and the counter stops until the next byte arrives.
  - Operand register contents are not cleared.
- Macro not defined: no counter is built, `timeout` is tied to 0, and a partial transaction waits indefinitely.

## Structure
- Shared package `serial_link_pkg`:
  - FSM state encoding: COLLECT=2'd0, READY=2'd1, SEND=2'd2.
  - Frame constants: DATA_BITS=8, FRAME_BITS=10.
  - A clog2-based helper for index widths.
- One sub-module, `uart_rx_core`: oversampling receiver with synchroniser, outputting `rx_byte`, `rx_valid` and `rx_frame_err`.
- The transmitter, byte FSM and timeout counter live in the top module.

## Test plan
- Sim parameters: CLK_FREQUENCY=1_536_000, BAUD_RATE=9600 (SAMPLE_DIV=10, bit period = 160 clk).
- Reset, then idle 5 bit periods -> `dout`=1, `ready`=0, `operands`=0, no pulses.
- Defaults; send 0x12 then 0x34 -> `operands`=16'h3412; `ready` high 1 cycle after the second strobe; an extra byte 0x99 -> `rx_overrun` pulse, `operands` unchanged.
- OPERAND_BYTES=2; send 0xCD, 0xAB, 0x01, 0x00 -> operand0=16'hABCD, operand1=16'h0001, `ready`=1.
- RESULT_BYTES=2, `result`=16'hBEEF, `tx_en` pulse in READY -> `dout` carries frame 0xEF then 0xBE, 160 clk/bit, 3200 clk total. `tx_busy` spans exactly that window, then the FSM is in COLLECT.
- Send 0x55 with stop bit 0 -> `frame_error` pulse, index unchanged; then 0x12, 0x34 -> `ready`=1.
- With SERIAL_LINK_TIMEOUT_EN: send 0x12, idle 20 bit periods -> `timeout` pulse; then 0x56, 0x78 -> `operands`=16'h7856. Without the macro, the same stimulus gives `operands`=16'h5612.
